// File: rtl/wb_pkg.sv
// Shared write-back decode definitions: opcodes, the decoded-destination type and the decode helper.
package wb_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  typedef struct packed {
    logic       has_dest;
    logic [4:0] dest;
  } wb_dest_t;

  // I-type writers target the rt field, R-type writers target the rd field.
  function automatic void wb_dest(input logic [31:0] instr, output logic valid,
                                  output logic [4:0] dest);
    valid = 1'b0;
    dest  = instr[20:16];
    case (instr[31:26])
      OP_LW, OP_ADDI: begin
        valid = 1'b1;
        dest  = instr[20:16];
      end
      OP_RTYPE: begin
        valid = 1'b1;
        dest  = instr[15:11];
      end
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/wb_dest_decode.sv
// Destination decoder for an instruction leaving MEM; shared with the ID-stage hazard unit.
module wb_dest_decode
  import wb_pkg::*;
(
  input  logic [31:0] instr,
  output wb_dest_t    dec
);

  logic       has_dest;
  logic [4:0] dest;
  logic       unused_fields;

  always_comb begin
    has_dest = 1'b0;
    dest     = '0;
    wb_dest(instr, has_dest, dest);
  end

  assign dec           = '{has_dest: has_dest, dest: dest};
  assign unused_fields = ^{instr[25:21], instr[10:0]};

endmodule

// File: rtl/wb_regfile_sb.sv
// Write-back register file with write-through read bypass and a per-register
// pending-write scoreboard used by ID-stage hazard detection.
module wb_regfile_sb
  import wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 2,
  parameter int INIT_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [31:0]       wb_instr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              busy_rs,
  output logic              busy_rt,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  output logic              err_underflow
);

  localparam int               DEPTH   = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_dest_t          dec;
  logic [ADDR_W-1:0] dest_idx;
  logic              we;
  logic              inc;
  logic              err_q;

  // Indices 0 and >= NUM_REGS are tied to zero so every lookup below is total.
  logic [DATA_W-1:0] reg_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q [DEPTH];

  wb_dest_decode u_dest_decode (
    .instr (wb_instr),
    .dec   (dec)
  );

  assign dest_idx = ADDR_W'(dec.dest);
  assign we       = wb_valid & dec.has_dest & (dec.dest != 5'd0) & (32'(dec.dest) < NUM_REGS);

  assign issue_ready = (cnt_q[issue_rd] != CNT_MAX);
  assign inc         = issue_valid & issue_ready & (issue_rd != '0) & (32'(issue_rd) < NUM_REGS);

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if (g == 0 || g >= NUM_REGS) begin : g_zero
      assign reg_q[g] = '0;
      assign cnt_q[g] = '0;
    end else begin : g_live
      logic [DATA_W-1:0] q;
      logic [CNT_W-1:0]  c;
      logic              hit_wr;
      logic              hit_issue;
      logic              retire;

      assign hit_wr    = we & (dest_idx == ADDR_W'(g));
      assign hit_issue = inc & (issue_rd == ADDR_W'(g));
      // A write-back to an idle register still lands but never retires an issue.
      assign retire    = hit_wr & (c != '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          q <= (INIT_MODE == 1) ? DATA_W'(g) : '0;
          c <= '0;
        end else begin
          if (hit_wr) q <= wb_data;
          if (hit_issue && !retire)      c <= c + CNT_W'(1);
          else if (retire && !hit_issue) c <= c - CNT_W'(1);
        end
      end

      assign reg_q[g] = q;
      assign cnt_q[g] = c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              err_q <= 1'b0;
    else if (we && cnt_q[dest_idx] == '0) err_q <= 1'b1;
  end

  assign err_underflow = err_q;

  // we already excludes reg 0 and out-of-range destinations, so a bare index match is enough.
  assign rs_data = (we && rs_addr == dest_idx) ? wb_data : reg_q[rs_addr];
  assign rt_data = (we && rt_addr == dest_idx) ? wb_data : reg_q[rt_addr];

  assign busy_rs = (cnt_q[rs_addr] != '0) &
                   !((cnt_q[rs_addr] == CNT_W'(1)) & we & (rs_addr == dest_idx));
  assign busy_rt = (cnt_q[rt_addr] != '0) &
                   !((cnt_q[rt_addr] == CNT_W'(1)) & we & (rt_addr == dest_idx));

endmodule
